sine_voice_mixer: RTL and testbench
===================================

Name: sine_voice_mixer

Overview:
- Multi-voice phase-accumulator oscillator that drives the shared quarter-wave sine lookup table. The table takes a 9-bit address and returns a registered, signed 16-bit value.
- On each audio sample tick, the block steps through NUM_VOICES voices in turn. For each voice it issues a table address, scales the returned sine value by that voice's volume, and sums the results.
- The summed frame is saturated to 16 bits and presented through a valid/ready handshake to the downstream audio output stage.

Parameters:
- NUM_VOICES, 4, number of time-multiplexed voices (power of two, 2..16).
- PHASE_W, 24, phase accumulator and tuning-word width in bits.
- ADDR_W, 9, sine table address width; taken from phase[PHASE_W-1 -: ADDR_W].
- SAMPLE_W, 16, signed table data width and mix output width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle pulse at the audio sample rate.
- cfg_we  in  1  voice configuration write strobe.
- cfg_voice  in  $clog2(NUM_VOICES)  voice index for the write.
- cfg_ftw  in  PHASE_W  frequency tuning word.
- cfg_vol  in  8  unsigned volume; 255 ≈ unity.
- cfg_gate  in  1  voice enable.
- lut_addr  out  ADDR_W  registered address to the sine table.
- lut_data  in  SAMPLE_W  signed table output; valid one cycle after lut_addr.
- mix_out  out  SAMPLE_W  signed, saturated mixed sample.
- mix_valid  out  1  mix_out is valid.
- mix_ready  in  1  downstream accepts mix_out.
- overrun  out  1  sticky flag: a tick arrived while a frame was busy or held.

Behaviour:
- Reset values:
  - state = IDLE.
  - All phase, ftw, vol and gate registers = 0.
  - lut_addr = 0, mix_out = 0, mix_valid = 0, overrun = 0.
  - Reset asserted mid-frame discards the frame; no mix_valid is produced for it.
- Config writes:
  - On cfg_we, the selected voice's ftw, vol and gate registers are updated in that cycle.
  - A write with cfg_gate = 1 while the stored gate = 0 (trigger) forces that voice's phase to 0.
  - While gate = 0, the voice's phase is held at 0.
- States: IDLE, RUN, DRAIN, HOLD.
- IDLE:
  - When sample_tick = 1: clear the accumulator, set issue index i = 0, go to RUN.
- RUN (one voice issued per cycle, voice i in cycle i):
  - lut_addr <= top ADDR_W bits of phase[i], using the pre-increment phase.
  - phase[i] <= phase[i] + ftw[i], wrapping modulo 2^PHASE_W.
  - vol[i] and gate[i] are captured into the pipeline in the same cycle.
  - After voice NUM_VOICES-1 is issued, go to DRAIN.
- Accumulate (one cycle behind issue):
  - In the cycle after voice i is issued, product = lut_data (signed) × {0, vol} (signed 9-bit).
  - The product is arithmetic-shifted right by 8, then added to an accumulator of width SAMPLE_W + $clog2(NUM_VOICES) + 1.
  - A voice whose captured gate = 0 contributes 0.
- DRAIN:
  - Final accumulate, then mix_out <= clamp(acc, -2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1), mix_valid <= 1, go to HOLD.
- Latency:
  - If sample_tick is sampled in cycle 0, mix_valid is first high in cycle NUM_VOICES + 3 (cycle 7 for the default NUM_VOICES = 4).
- HOLD:
  - mix_out and mix_valid stay stable until mix_ready = 1.
  - On mix_ready = 1: mix_valid <= 0, go to IDLE.
  - A sample_tick in the same cycle as the accepting mix_ready is treated as an overrun.
- Overrun:
  - A sample_tick in RUN, DRAIN or HOLD is dropped and sets overrun = 1.
  - overrun is cleared only by reset.
- Config write colliding with an issue:
  - The issue uses the old phase (for the address), old vol and old gate.
  - The next phase is 0 on a trigger; otherwise it is old phase + old ftw.
  - The new ftw, vol and gate apply from the next frame.
- lut_addr holds its last value while in IDLE and HOLD.

Decomposition:
- Package nco_pkg holds:
  - PHASE_W, ADDR_W and SAMPLE_W defaults.
  - The state enum.
  - voice_cfg_t struct {ftw, vol, gate}.
  - SAT_MAX and SAT_MIN constants.
- One sub-module: nco_voice_scaler, a registered signed-by-unsigned multiply with arithmetic shift right by 8 and a gate mask.

Test Plan:
- Reset check: pulse reset, then a tick with all gates at 0 → lut_addr = 0, overrun = 0, and mix_out = 0x0000 delivered 7 cycles after the tick.
- Single voice: voice 0 with gate = 1, vol = 255, ftw = 0x008000; the LUT model returns 0x7FFD; mix_ready = 1.
  - lut_addr for voice 0 is 0, 1, 2, … on successive frames.
  - mix_out = 0x7F7D each frame.
  - mix_valid rises exactly 7 cycles after each tick.
- Saturation: 4 voices with gate = 1, vol = 255.
  - LUT model returns 0x7FFD → mix_out = 0x7FFF.
  - LUT model returns 0x8003 → mix_out = 0x8000.
- Phase wrap: ftw = 0xC00000 from phase 0 → lut_addr for that voice is 0, 384, 256, 128, 0 on successive frames.
- Backpressure and overrun:
  - Hold mix_ready = 0 and send two ticks → mix_out stays stable, overrun = 1, and no extra frame is produced.
  - Raise mix_ready → mix_valid drops; the next tick yields a fresh frame.
- Trigger and reset mid-frame:
  - Write gate 0 → 1 to voice 2 during its issue cycle → voice 2 issues address 0 in the next frame.
  - Assert reset in RUN → mix_valid stays 0 and lut_addr = 0 the cycle after.

Source files
------------

// File: rtl/nco_pkg.sv
// -----------------------------------------------------------------------------
// nco_pkg
// Shared definitions for the multi-voice sine oscillator/mixer:
//   - default widths for phase, table address and sample data
//   - mixer sequencing states
//   - per-voice configuration record
//   - saturation limits for the mixed output
// -----------------------------------------------------------------------------
package nco_pkg;

   localparam int DEF_PHASE_W  = 24;
   localparam int DEF_ADDR_W   = 9;
   localparam int DEF_SAMPLE_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_HOLD
   } mix_state_t;

   typedef struct packed {
      logic [DEF_PHASE_W-1:0] ftw;
      logic [7:0]             vol;
      logic                   gate;
   } voice_cfg_t;

   localparam logic signed [DEF_SAMPLE_W-1:0] SAT_MAX = {1'b0, {(DEF_SAMPLE_W-1){1'b1}}};
   localparam logic signed [DEF_SAMPLE_W-1:0] SAT_MIN = {1'b1, {(DEF_SAMPLE_W-1){1'b0}}};

endpackage

// File: rtl/nco_voice_scaler.sv
// -----------------------------------------------------------------------------
// nco_voice_scaler
// One-stage registered volume scaler: signed sample x unsigned 8-bit volume,
// arithmetic shift right by 8, forced to zero when the voice gate is off.
// Ports:
//   clk          system clock
//   i_rst        synchronous active-high reset (valid/last only)
//   i_vld_p0     input sample valid
//   i_last_p0    input belongs to the last voice of the frame
//   i_sample_p0  signed table sample
//   i_vol_p0     unsigned volume (255 ~ unity)
//   i_gate_p0    voice enable captured at issue
//   o_vld_p1     scaled product valid
//   o_last_p1    scaled product belongs to the last voice
//   o_prod_p1    signed scaled product (SAMPLE_W+1 bits)
// -----------------------------------------------------------------------------
module nco_voice_scaler
   import nco_pkg::*;
#(
   parameter int SAMPLE_W = DEF_SAMPLE_W
) (
   input  logic                clk,
   input  logic                i_rst,
   input  logic                i_vld_p0,
   input  logic                i_last_p0,
   input  logic [SAMPLE_W-1:0] i_sample_p0,
   input  logic [7:0]          i_vol_p0,
   input  logic                i_gate_p0,
   output logic                o_vld_p1,
   output logic                o_last_p1,
   output logic [SAMPLE_W:0]   o_prod_p1
);

   localparam int PROD_W = SAMPLE_W + 9;

   // Volume is zero-extended to 9 bits so the multiply stays signed; dropping
   // the low 8 product bits is the arithmetic shift right by 8.
   function automatic logic signed [SAMPLE_W:0] scale_sample(
      input logic signed [SAMPLE_W-1:0] s,
      input logic        [7:0]          v
   );
      logic signed [PROD_W-1:0] p;
      p = s * $signed({1'b0, v});
      scale_sample = p[PROD_W-1:8];
   endfunction

   logic signed [SAMPLE_W:0] r_prod_p1;
   logic                     r_vld_p1;
   logic                     r_last_p1;

   // ---- stage p0 -> p1 ----
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_vld_p1  <= 1'b0;
         r_last_p1 <= 1'b0;
      end else begin
         r_vld_p1  <= i_vld_p0;
         r_last_p1 <= i_vld_p0 & i_last_p0;
      end
      r_prod_p1 <= i_gate_p0 ? scale_sample(i_sample_p0, i_vol_p0) : '0;
   end

   assign o_vld_p1  = r_vld_p1;
   assign o_last_p1 = r_last_p1;
   assign o_prod_p1 = r_prod_p1;

endmodule

// File: rtl/sine_voice_mixer.sv
// -----------------------------------------------------------------------------
// sine_voice_mixer
// Time-multiplexed phase-accumulator oscillator bank. Each sample tick walks
// all voices once: issues a quarter-wave table address per voice, scales the
// returned sample by the voice volume, sums the frame, saturates it and holds
// it on a valid/ready output until accepted.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   sample_tick   one-cycle pulse per audio sample
//   cfg_we        voice config write strobe (cfg_voice, cfg_ftw, cfg_vol, cfg_gate)
//   lut_addr      registered sine table address
//   lut_data      signed table output, valid the cycle after an issue
//   mix_out       saturated mixed sample, qualified by mix_valid
//   mix_ready     downstream accepts mix_out
//   overrun       sticky: a tick arrived while a frame was in progress or held
// -----------------------------------------------------------------------------
module sine_voice_mixer
   import nco_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int PHASE_W    = DEF_PHASE_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int SAMPLE_W   = DEF_SAMPLE_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sample_tick,
   input  logic                          cfg_we,
   input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
   input  logic [PHASE_W-1:0]            cfg_ftw,
   input  logic [7:0]                    cfg_vol,
   input  logic                          cfg_gate,
   output logic [ADDR_W-1:0]             lut_addr,
   input  logic [SAMPLE_W-1:0]           lut_data,
   output logic [SAMPLE_W-1:0]           mix_out,
   output logic                          mix_valid,
   input  logic                          mix_ready,
   output logic                          overrun
);

   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam int ACC_W = SAMPLE_W + IDX_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   function automatic logic [SAMPLE_W-1:0] sat_mix(input logic signed [ACC_W-1:0] a);
      if (a > ACC_W'(SAT_MAX))
         sat_mix = SAT_MAX;
      else if (a < ACC_W'(SAT_MIN))
         sat_mix = SAT_MIN;
      else
         sat_mix = a[SAMPLE_W-1:0];
   endfunction

   mix_state_t          r_state;
   logic [IDX_W-1:0]    r_idx;
   voice_cfg_t          r_cfg   [NUM_VOICES];
   logic [PHASE_W-1:0]  r_phase [NUM_VOICES];

   logic                r_vld_p0;
   logic                r_last_p0;
   logic [7:0]          r_vol_p0;
   logic                r_gate_p0;

   logic                     w_vld_p1;
   logic                     w_last_p1;
   logic signed [SAMPLE_W:0] w_prod_p1;

   logic signed [ACC_W-1:0]  r_acc_p2;
   logic signed [ACC_W-1:0]  w_acc_sum;
   logic                     w_issue;

   assign w_issue   = (r_state == ST_RUN);
   assign w_acc_sum = r_acc_p2 + ACC_W'(w_prod_p1);

   // Phase and configuration. A voice with its stored gate low sits at phase 0,
   // which also covers the trigger case (gate 0 -> 1 write) for the next cycle.
   // An issue in the same cycle as a config write uses the old registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_phase[v] <= '0;
            r_cfg[v]   <= '0;
         end
      end else begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (!r_cfg[v].gate)
               r_phase[v] <= '0;
            else if (w_issue && (r_idx == IDX_W'(v)))
               r_phase[v] <= r_phase[v] + PHASE_W'(r_cfg[v].ftw);
         end
         if (cfg_we) begin
            r_cfg[cfg_voice].ftw  <= DEF_PHASE_W'(cfg_ftw);
            r_cfg[cfg_voice].vol  <= cfg_vol;
            r_cfg[cfg_voice].gate <= cfg_gate;
         end
      end
   end

   // ---- issue stage p0 -> scaler p1 ----
   nco_voice_scaler #(
      .SAMPLE_W (SAMPLE_W)
   ) u_scaler (
      .clk         (clk),
      .i_rst       (reset),
      .i_vld_p0    (r_vld_p0),
      .i_last_p0   (r_last_p0),
      .i_sample_p0 (lut_data),
      .i_vol_p0    (r_vol_p0),
      .i_gate_p0   (r_gate_p0),
      .o_vld_p1    (w_vld_p1),
      .o_last_p1   (w_last_p1),
      .o_prod_p1   (w_prod_p1)
   );

   // ---- accumulate stage p1 -> p2, sequencing and output ----
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_vld_p0  <= 1'b0;
         r_last_p0 <= 1'b0;
         lut_addr  <= '0;
         mix_out   <= '0;
         mix_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         r_vld_p0  <= 1'b0;
         r_last_p0 <= 1'b0;
         if (w_vld_p1)
            r_acc_p2 <= w_acc_sum;

         case (r_state)
            ST_IDLE: begin
               if (sample_tick) begin
                  r_acc_p2 <= '0;
                  r_idx    <= '0;
                  r_state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (sample_tick)
                  overrun <= 1'b1;
               lut_addr  <= r_phase[r_idx][PHASE_W-1 -: ADDR_W];
               r_vol_p0  <= r_cfg[r_idx].vol;
               r_gate_p0 <= r_cfg[r_idx].gate;
               r_vld_p0  <= 1'b1;
               r_last_p0 <= (r_idx == LAST_IDX);
               r_idx     <= r_idx + IDX_W'(1);
               if (r_idx == LAST_IDX)
                  r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (sample_tick)
                  overrun <= 1'b1;
               // The last voice's product is folded in directly so the frame
               // leaves without an extra accumulator cycle.
               if (w_vld_p1 && w_last_p1) begin
                  mix_out   <= sat_mix(w_acc_sum);
                  mix_valid <= 1'b1;
                  r_state   <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (sample_tick)
                  overrun <= 1'b1;
               if (mix_ready) begin
                  mix_valid <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sine_voice_mixer.sv
module tb_sine_voice_mixer;

   localparam int NV = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_tick = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_voice = '0;
   logic [23:0] cfg_ftw = '0;
   logic [7:0]  cfg_vol = '0;
   logic        cfg_gate = 1'b0;
   logic [8:0]  lut_addr;
   logic [15:0] lut_data;
   logic [15:0] mix_out;
   logic        mix_valid;
   logic        mix_ready = 1'b1;
   logic        overrun;

   logic [15:0] lut_val = 16'h0000;
   logic [15:0] lut_q;
   logic [8:0]  addr_seen [NV];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Table model: constant value, registered like the real table.
   always_ff @(posedge clk) lut_q <= lut_val;
   assign lut_data = lut_q;

   sine_voice_mixer #(
      .NUM_VOICES (NV),
      .PHASE_W    (24),
      .ADDR_W     (9),
      .SAMPLE_W   (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sample_tick (sample_tick),
      .cfg_we      (cfg_we),
      .cfg_voice   (cfg_voice),
      .cfg_ftw     (cfg_ftw),
      .cfg_vol     (cfg_vol),
      .cfg_gate    (cfg_gate),
      .lut_addr    (lut_addr),
      .lut_data    (lut_data),
      .mix_out     (mix_out),
      .mix_valid   (mix_valid),
      .mix_ready   (mix_ready),
      .overrun     (overrun)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int v, input logic [23:0] ftw, input logic [7:0] vol,
                            input logic gate);
      cfg_we    = 1'b1;
      cfg_voice = 2'(v);
      cfg_ftw   = ftw;
      cfg_vol   = vol;
      cfg_gate  = gate;
      step();
      cfg_we    = 1'b0;
   endtask

   // Sends one tick and waits (bounded) for mix_valid. lat counts edges from
   // the edge that samples the tick (1) to the edge after which mix_valid is
   // high. Records the address issued for each voice. Optionally writes a
   // trigger (gate 1, vol 255, ftw 0x010000) to trig_voice in its issue cycle.
   task automatic run_frame(input int trig_voice, output int lat, output logic [15:0] mout);
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      lat = 1;
      while (!mix_valid && lat < 20) begin
         if (trig_voice >= 0 && lat == trig_voice + 1) begin
            cfg_we    = 1'b1;
            cfg_voice = 2'(trig_voice);
            cfg_ftw   = 24'h010000;
            cfg_vol   = 8'd255;
            cfg_gate  = 1'b1;
         end else begin
            cfg_we = 1'b0;
         end
         step();
         lat++;
         if (lat >= 2 && lat <= NV + 1)
            addr_seen[lat-2] = lut_addr;
      end
      cfg_we = 1'b0;
      mout = mix_out;
   endtask

   task automatic frame_check(input string tag, input int trig_voice, input logic [15:0] exp_mix);
      int lat;
      logic [15:0] m;
      run_frame(trig_voice, lat, m);
      chk({tag, "_lat"}, 32'(lat), 32'd7);
      chk({tag, "_mix"}, 32'(m), 32'(exp_mix));
      if (mix_ready)
         step();
   endtask

   initial begin
      int lat;
      int seen;
      logic [15:0] m;
      logic [15:0] held;
      string tg;

      // Reset state
      repeat (3) step();
      reset = 1'b0;
      step();
      chk("rst_addr", 32'(lut_addr), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      chk("rst_valid", 32'(mix_valid), 32'd0);
      chk("rst_mix", 32'(mix_out), 32'd0);

      // All gates off: silent frame
      lut_val = 16'h7FFD;
      step();
      frame_check("silent", -1, 16'h0000);
      chk("silent_ovr", 32'(overrun), 32'd0);

      // Single voice, address walks 0,1,2
      cfg_write(0, 24'h008000, 8'd255, 1'b1);
      for (int f = 0; f < 3; f++) begin
         tg = $sformatf("single%0d", f);
         frame_check(tg, -1, 16'h7F7D);
         chk({tg, "_addr"}, 32'(addr_seen[0]), 32'(f));
      end

      // Phase wrap on voice 1 (vol 0 so the mix is unchanged)
      cfg_write(1, 24'hC00000, 8'd0, 1'b1);
      begin
         logic [8:0] exp_wrap [5];
         exp_wrap = '{9'd0, 9'd384, 9'd256, 9'd128, 9'd0};
         for (int f = 0; f < 5; f++) begin
            tg = $sformatf("wrap%0d", f);
            frame_check(tg, -1, 16'h7F7D);
            chk({tg, "_addr"}, 32'(addr_seen[1]), 32'(exp_wrap[f]));
         end
      end

      // Saturation, positive then negative
      cfg_write(1, 24'hC00000, 8'd255, 1'b1);
      cfg_write(2, 24'h000000, 8'd255, 1'b1);
      cfg_write(3, 24'h000000, 8'd255, 1'b1);
      step();
      frame_check("sat_pos", -1, 16'h7FFF);
      lut_val = 16'h8003;
      step();
      step();
      frame_check("sat_neg", -1, 16'h8000);

      // Backpressure and overrun
      mix_ready = 1'b0;
      run_frame(-1, lat, held);
      chk("bp_lat", 32'(lat), 32'd7);
      chk("bp_mix", 32'(held), 32'h8000);
      lut_val = 16'h0100;
      for (int t = 0; t < 2; t++) begin
         sample_tick = 1'b1;
         step();
         sample_tick = 1'b0;
         step();
      end
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (!mix_valid || mix_out !== held)
            seen++;
      end
      chk("bp_stable", 32'(seen), 32'd0);
      chk("bp_valid", 32'(mix_valid), 32'd1);
      chk("bp_ovr", 32'(overrun), 32'd1);
      mix_ready = 1'b1;
      step();
      chk("bp_release", 32'(mix_valid), 32'd0);
      step();
      frame_check("bp_fresh", -1, 16'h03FC);

      // Trigger voice 2 during its issue cycle
      cfg_write(2, 24'h000000, 8'd255, 1'b0);
      step();
      frame_check("trig0", 2, 16'h02FD);
      chk("trig0_addr", 32'(addr_seen[2]), 32'd0);
      frame_check("trig1", -1, 16'h03FC);
      chk("trig1_addr", 32'(addr_seen[2]), 32'd0);
      frame_check("trig2", -1, 16'h03FC);
      chk("trig2_addr", 32'(addr_seen[2]), 32'd2);

      // Reset in the middle of a frame
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      step();
      chk("midrst_pre_addr_nz", 32'(lut_addr != 9'd0), 32'd1);
      reset = 1'b1;
      step();
      chk("midrst_addr", 32'(lut_addr), 32'd0);
      chk("midrst_valid", 32'(mix_valid), 32'd0);
      chk("midrst_ovr", 32'(overrun), 32'd0);
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (mix_valid)
            seen++;
      end
      chk("midrst_noframe", 32'(seen), 32'd0);
      frame_check("post_rst", -1, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
